multiplier: RTL
===============

# multiplier

Iterative 32x32 integer multiplier serving the RISC-V M-extension multiply instructions (MUL, MULH, MULHSU, MULHU) in the core's execute stage. It is the multiply counterpart of the core's iterative divider and uses the same start/busy handshake. Operands are converted to magnitudes and multiplied by radix-2 shift-add over 32 step cycles. The result is sign-corrected and the selected 32-bit half is held in an output register until the next operation completes.

## Interface
- No parameters; data width fixed at 32.
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  mul_op_t: MUL=0 (low half), MULH=1 (signed x signed, high), MULHSU=2 (signed rs1 x unsigned rs2, high), MULHU=3 (unsigned x unsigned, high)
- multiplicand_input  input  32  rs1 operand
- multiplier_input  input  32  rs2 operand
- result_output  output  32  registered result of the last completed operation
- done  output  1  one-cycle pulse in the cycle result_output first shows a new value
- busy  output  1  high while in STEP

## Operation
- States (mul_state_t): IDLE, STEP.
- IDLE with start=1:
  - latch op;
  - sign_a = rs1[31] when op is MULH or MULHSU, else 0;
  - sign_b = rs2[31] when op is MULH, else 0;
  - mag_a = sign_a ? -rs1 : rs1, zero-extended to 64 bits;
  - mag_b = sign_b ? -rs2 : rs2;
  - product = 0, counter = 31; go to STEP.
- IDLE with start=0: hold all registers.
- STEP, every cycle:
  - if mag_b[0], product += mag_a (64-bit, no overflow possible);
  - then mag_a <<= 1 and mag_b >>= 1;
  - if counter != 0, decrement it.
- STEP with counter == 0: this is the final step, including that step's add.
  - p = (sign_a ^ sign_b) ? -product_next : product_next, negated in 64-bit two's complement;
  - result_output <= (op == MUL) ? p[31:0] : p[63:32];
  - done <= 1; go to IDLE.
- Magnitude of 0x80000000 is 0x80000000 read as unsigned. This is correct, not an error.
- For MUL, the low half is identical for every signedness, so treat MUL as unsigned.
- There is no early termination: zero or small operands still take the full 32 steps.
- start while busy is ignored; the operation in flight is unaffected.
- Operand and op inputs matter only in the accepting cycle and may change afterwards.

## Timing
- Cycle 0: start=1 in IDLE.
- Cycles 1..32: busy=1 (STEP).
- Cycle 32 edge: result_output updates. From cycle 33: done=1 for one cycle, busy=0, state IDLE.
- Back-to-back: start may be asserted in the done cycle (33) and is accepted then. Sustained throughput is one multiply per 33 cycles.
- result_output is stable from its update until the next completion. It is never disturbed by start or operand changes.
- Reset values: state IDLE, busy=0, done=0, result_output=0, and counter, product, mag_a, mag_b, signs and op all 0.
- Reset mid-operation: abort immediately. The cycle after reset shows IDLE, busy=0, done=0 and result_output=0. No partial result is ever written.
- Reset has priority over start in the same cycle.

## Structure
- mul_op_t and mul_state_t enums go in the shared core package, beside the divider's state enum. The decoder drives op from that package (funct3[1:0]).
- Single module, no sub-module. The datapath is one 64-bit adder plus shifters, and negation is done in-line.
- Estimated RTL: about 150 lines.

## Test plan
- MUL 7 x 6 -> result 0x0000002A. busy is high exactly 32 cycles; done pulses once, in cycle 33.
- MUL 0xFFFFFFFD (-3) x 5 -> 0xFFFFFFF1. MULH with the same operands -> 0xFFFFFFFF.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF (product 0xFFFFFFFF00000001). MULHSU 0x00000002 x 0x80000000 -> 0x00000001.
- Start a MUL 3 x 4, then pulse start with other operands at cycle 10 -> the second request is ignored; result is 0x0000000C at cycle 33.
- Start a multiply and assert reset at cycle 15 -> busy=0, result_output=0, no done pulse. The next start then completes normally.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared types for the iterative multiplier: op encoding and FSM states.
package multiplier_pkg;

  // Encoding matches funct3[1:0] of the M-extension multiply group.
  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } mul_state_t;

  localparam int unsigned MUL_W     = 32;
  localparam int unsigned MUL_STEPS = 32;

endpackage

// File: rtl/multiplier_if.sv
// Request/response bundle between the execute stage and the multiplier.
interface multiplier_if;
  import multiplier_pkg::*;

  logic        start;
  mul_op_t     op;
  logic [31:0] multiplicand_input;
  logic [31:0] multiplier_input;
  logic [31:0] result_output;
  logic        done;
  logic        busy;

  modport master (
    output start, op, multiplicand_input, multiplier_input,
    input  result_output, done, busy
  );

  modport slave (
    input  start, op, multiplicand_input, multiplier_input,
    output result_output, done, busy
  );

endinterface

// File: rtl/multiplier.sv
// Iterative radix-2 shift-add 32x32 multiplier for MUL/MULH/MULHSU/MULHU.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result_output holds last completed value
// STEP  | one shift-add step per cycle, 32 steps, counter 31 down to 0
module multiplier
  import multiplier_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  multiplier_if.slave  bus
);

  mul_state_t  state;
  mul_state_t  state_next;
  mul_op_t     op_q;
  logic        sign_a;
  logic        sign_b;
  logic [63:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] product;
  logic [4:0]  counter;
  logic [31:0] result_q;
  logic        done_q;

  logic        sign_a_in;
  logic        sign_b_in;
  logic [31:0] mag_a_in;
  logic [31:0] mag_b_in;
  logic [63:0] product_next;
  logic [63:0] product_fix;

  // Operand signs and magnitudes for the accepting cycle; MUL runs unsigned
  // since its low half is the same for every signedness.
  always_comb begin
    sign_a_in = 1'b0;
    sign_b_in = 1'b0;
    if (bus.op == OP_MULH || bus.op == OP_MULHSU) sign_a_in = bus.multiplicand_input[31];
    if (bus.op == OP_MULH)                        sign_b_in = bus.multiplier_input[31];
    mag_a_in = sign_a_in ? (~bus.multiplicand_input + 32'd1) : bus.multiplicand_input;
    mag_b_in = sign_b_in ? (~bus.multiplier_input + 32'd1) : bus.multiplier_input;
  end

  // One adder step plus the sign correction applied on the final step.
  always_comb begin
    product_next = product + (mag_b[0] ? mag_a : 64'd0);
    product_fix  = (sign_a ^ sign_b) ? (~product_next + 64'd1) : product_next;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start)      state_next = STEP;
      STEP: if (counter == 5'd0) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Outputs derived from state.
  always_comb begin
    bus.busy = (state == STEP);
  end

  // Datapath registers: operand latch, shift-add steps, result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_MUL;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      mag_a    <= 64'd0;
      mag_b    <= 32'd0;
      product  <= 64'd0;
      counter  <= 5'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            sign_a  <= sign_a_in;
            sign_b  <= sign_b_in;
            mag_a   <= {32'd0, mag_a_in};
            mag_b   <= mag_b_in;
            product <= 64'd0;
            counter <= 5'(MUL_STEPS - 1);
          end
        end
        STEP: begin
          product <= product_next;
          mag_a   <= mag_a << 1;
          mag_b   <= mag_b >> 1;
          if (counter != 5'd0) begin
            counter <= counter - 5'd1;
          end else begin
            result_q <= (op_q == OP_MUL) ? product_fix[31:0] : product_fix[63:32];
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_output = result_q;
  assign bus.done          = done_q;

endmodule
